// File: rtl/axis_register_slice.sv
// Two-entry valid/ready skid buffer: registered S_READY, M_VALID and M_DATA,
// 1-cycle latency, 1 beat/cycle sustained, strict FIFO order.
module axis_register_slice #(
    parameter int unsigned           DATA_WIDTH  = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  FLUSH,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic [1:0]            OCCUPANCY
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  m_valid_q, m_valid_d;
    logic                  s_ready_q, s_ready_d;
    logic [1:0]            occ_q, occ_d;
    logic                  s_fire_s;
    logic                  m_fire_s;

    // Next-state and datapath selection; handshakes use only registered outputs.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        s_fire_s = S_VALID & s_ready_q;
        m_fire_s = m_valid_q & M_READY;
        case (state_q)
            ST_EMPTY: begin
                if (s_fire_s) begin
                    state_d = ST_BUSY;
                    main_d  = S_DATA;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (s_fire_s && m_fire_s) begin
                    state_d = ST_BUSY;
                    main_d  = S_DATA;
                end else if (s_fire_s) begin
                    // Downstream stalled: park the new beat behind the presented one.
                    state_d = ST_FULL;
                    skid_d  = S_DATA;
                end else if (m_fire_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_FULL: begin
                if (m_fire_s) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Output flags decoded from the next state so they can be registered.
    always_comb begin
        m_valid_d = 1'b0;
        s_ready_d = 1'b1;
        occ_d     = 2'd0;
        case (state_d)
            ST_EMPTY: begin
                m_valid_d = 1'b0;
                s_ready_d = 1'b1;
                occ_d     = 2'd0;
            end
            ST_BUSY: begin
                m_valid_d = 1'b1;
                s_ready_d = 1'b1;
                occ_d     = 2'd1;
            end
            ST_FULL: begin
                m_valid_d = 1'b1;
                s_ready_d = 1'b0;
                occ_d     = 2'd2;
            end
            default: begin
                m_valid_d = 1'b0;
                s_ready_d = 1'b1;
                occ_d     = 2'd0;
            end
        endcase
    end

    // State and storage registers; reset and flush both discard every held beat.
    always_ff @(posedge CLK) begin
        if (!RSTN || FLUSH) begin
            state_q   <= ST_EMPTY;
            main_q    <= RESET_VALUE;
            skid_q    <= RESET_VALUE;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            occ_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            occ_q     <= occ_d;
        end
    end

    assign S_READY   = s_ready_q;
    assign M_VALID   = m_valid_q;
    assign M_DATA    = main_q;
    assign OCCUPANCY = occ_q;

endmodule

// File: doc/axis_register_slice.md
Name: axis_register_slice

Overview:
- Full-throughput, two-entry valid/ready register slice (skid buffer) for the pipeline library.
- Sits directly downstream of a CE-driven register pipeline. It converts the pipeline's free-running output into a backpressure-capable stream.
- Breaks combinational paths on both data/valid and ready, so long handshake chains can be retimed.
- Latency is 1 cycle, sustained throughput is 1 beat/cycle, and the block never combinationally passes ready upstream.

Parameters:
- DATA_WIDTH, 1, width of the payload in bits.
- RESET_VALUE, 1'b0, value loaded into both data registers on reset and flush (zero-extended to DATA_WIDTH).

Ports:
- CLK  input  1  clock, all logic rising-edge.
- RSTN  input  1  reset, synchronous, active-low.
- FLUSH  input  1  synchronous clear of contents, active-high.
- S_VALID  input  1  upstream beat valid.
- S_READY  output  1  slice can accept a beat; registered.
- S_DATA  input  DATA_WIDTH  upstream payload.
- M_VALID  output  1  downstream beat valid; registered.
- M_READY  input  1  downstream accepts the beat.
- M_DATA  output  DATA_WIDTH  downstream payload; registered.
- OCCUPANCY  output  2  number of beats held, 0..2.

Behaviour:
- Handshake definitions:
  - s_fire = S_VALID & S_READY.
  - m_fire = M_VALID & M_READY.
  - A beat transfers on the rising edge where fire is high.
- Handshake rules:
  - M_VALID, once high, stays high and M_DATA stays stable until m_fire.
  - S_VALID may depend on S_READY; the slice's own outputs never depend combinationally on any input.
- Storage: main register (drives M_DATA) and skid register.
- State machine:
  - EMPTY: OCCUPANCY=0, M_VALID=0, S_READY=1.
  - BUSY: OCCUPANCY=1, M_VALID=1, S_READY=1.
  - FULL: OCCUPANCY=2, M_VALID=1, S_READY=0.
- Transitions (evaluated at each rising edge with RSTN=1, FLUSH=0):
  - EMPTY: s_fire -> BUSY, main<=S_DATA. Otherwise stay.
  - BUSY, s_fire & m_fire -> BUSY, main<=S_DATA.
  - BUSY, s_fire & !m_fire -> FULL, skid<=S_DATA, main unchanged.
  - BUSY, !s_fire & m_fire -> EMPTY.
  - BUSY, neither -> stay.
  - FULL: m_fire -> BUSY, main<=skid. Otherwise stay.
  - s_fire is impossible in FULL (S_READY=0).
- Ordering: strict FIFO; the skid beat is always presented before any later beat.
- Reset (RSTN=0 at an edge):
  - State becomes EMPTY; main and skid registers become RESET_VALUE.
  - Next cycle: M_VALID=0, S_READY=1, OCCUPANCY=0, M_DATA=RESET_VALUE.
  - While RSTN is held low the outputs hold these values.
  - S_READY must not depend on RSTN combinationally.
  - Reset mid-transfer discards all held beats; no beat is emitted after reset that was accepted before it.
- Flush (FLUSH=1 at an edge, RSTN=1):
  - Identical effect to reset.
  - A beat offered on the FLUSH cycle that sees S_READY=1 counts as accepted upstream and is discarded.
  - m_fire on the FLUSH cycle completes normally downstream (the beat was presented); the slice then goes EMPTY.
- Priority: RSTN > FLUSH > handshake.
- Throughput:
  - With M_READY held high, one beat per cycle, OCCUPANCY alternating 0/1 only.
  - Bubbles only come from S_VALID=0.
- Boundaries:
  - M_READY dropping while BUSY with s_fire fills the skid register; S_READY goes low in the following cycle.
  - Simultaneous S_VALID and M_READY in FULL drains one beat and does not accept.
- X-safety: S_DATA is captured only on s_fire; M_DATA never changes without a state transition or reset/flush.

Test Plan:
- Reset: hold RSTN=0 3 cycles with S_VALID=1, S_DATA=8'hAA -> M_VALID=0, S_READY=1, OCCUPANCY=0, M_DATA=RESET_VALUE. After release, first s_fire gives M_VALID=1, M_DATA=8'hAA 1 cycle later.
- Streaming: M_READY=1, send 0x01..0x10 back-to-back -> identical sequence on M_DATA, 1-cycle latency, no gaps, OCCUPANCY never 2.
- Backpressure: stream 0x01,0x02,0x03, M_READY=0 from the cycle 0x01 appears -> 0x02 goes to skid, S_READY=0, OCCUPANCY=2, 0x03 is held upstream. Raise M_READY -> output 0x01,0x02,0x03 in order, no loss or duplication.
- Flush: reach FULL with 0x11,0x22, assert FLUSH 1 cycle with S_VALID=1 and S_DATA=0x33 -> next cycle M_VALID=0, OCCUPANCY=0. None of 0x11, 0x22, 0x33 are ever emitted.
- Random: 10k cycles, random S_VALID/M_READY (50%) -> scoreboard matches in order, M_DATA is stable while M_VALID & !M_READY, S_READY == (OCCUPANCY!=2).
- Reset mid-FULL: FULL with 0x44,0x55, pulse RSTN=0 1 cycle -> EMPTY, and neither 0x44 nor 0x55 is ever emitted.
